riscv_mc_ctrl: RTL and testbench
================================

RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Parameter: MEM_TIMEOUT, default 15, maximum cycles held in MEM waiting for mem_rdy.
REQ-003 Port: CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: RST  input  1  reset, asynchronous and active-high.
REQ-005 Port: opcode  input  7  opcode of the instruction register.
REQ-006 Port: branch_taken  input  1  branch comparator result for the current instruction.
REQ-007 Port: halt_det  input  1  the current instruction is the halt instruction.
REQ-008 Port: mem_rdy  input  1  data memory completed the current access.
REQ-009 Port: ir_we  output  1  loads the instruction register.
REQ-010 Port: pc_we  output  1  updates the PC.
REQ-011 Port: pc_sel  output  2  next PC source: 0 pc+4, 1 branch target, 2 JAL target, 3 JALR target.
REQ-012 Port: rf_we  output  1  register file write enable.
REQ-013 Port: mem_en  output  1  data memory access request.
REQ-014 Port: mem_wen_n  output  1  data memory write enable, active-low.
REQ-015 Port: retire  output  1  one-cycle pulse when an instruction completes.
REQ-016 Port: num_inst  output  CNT_W  count of retired instructions.
REQ-017 Port: halt  output  1  sticky halt indication.
REQ-018 Port: err  output  1  sticky error for illegal opcode or memory timeout.
REQ-019 Port: state  output  3  current FSM state encoding, for debug.

Function
REQ-020 FSM states: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL go to IF on the next cycle.
REQ-021 IF SHALL assert ir_we for one cycle and go to ID.
REQ-022 ID, halt_det=1: go to HALT, assert retire, set halt.
REQ-023 ID, opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP, OP-IMM}: set err, assert pc_we with pc_sel=0, go to IF, no retire.
REQ-024 ID, any other case: go to EX.
REQ-025 EX, BRANCH: assert pc_we with pc_sel=1 if branch_taken else 0, assert retire, go to IF (3 cycles total).
REQ-026 EX, LOAD or STORE: go to MEM.
REQ-027 EX, all other legal opcodes: go to WB.
REQ-028 MEM: mem_en=1; mem_wen_n=0 only for STORE.
REQ-029 MEM, mem_rdy=0: stay in MEM with outputs held.
REQ-030 MEM, mem_rdy=1, STORE: pc_we with pc_sel=0, retire, go to IF.
REQ-031 MEM, mem_rdy=1, LOAD: go to WB.
REQ-032 MEM, MEM_TIMEOUT consecutive cycles with mem_rdy=0: set err, deassert mem_en, go to HALT, set halt.
REQ-033 WB: rf_we=1 and pc_we=1; pc_sel=2 for JAL, 3 for JALR, else 0; assert retire; go to IF. Latency is 4 cycles, or 5 for LOAD plus stall cycles.
REQ-034 HALT: all enables are 0 and the state is left only by reset.
REQ-035 num_inst SHALL increment by 1 on each retire and wrap from 2^CNT_W-1 to 0.
REQ-036 Except where stated above, enables SHALL be 0 and mem_wen_n SHALL be 1.
REQ-037 At most one of rf_we and mem_wen_n=0 SHALL be asserted in any cycle.

Reset
REQ-038 When RST=1, the block SHALL immediately take: state=IF, num_inst=0, halt=0, err=0, timeout counter=0, every enable 0, mem_wen_n=1.
REQ-039 Reset asserted in any state, including a stalled MEM, SHALL abort the instruction with no retire and no register-file or memory write.
REQ-040 On the first rising edge after RST deasserts, the block SHALL perform IF.

Configuration
REQ-041 Macro MC_CTRL_CYCLE_CNT_EN: when defined, the block SHALL add output cycle_cnt of width CNT_W, reset to 0, incrementing every cycle outside HALT and wrapping.
REQ-042 When MC_CTRL_CYCLE_CNT_EN is undefined, the cycle_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-043 Package riscv_mc_pkg SHALL hold the state encoding typedef, the RV32I opcode constants, and the pc_sel encodings.
REQ-044 The counters (num_inst and optional cycle_cnt) SHALL be one sub-module, mc_perf_cnt.

Verification
REQ-045 ADDI (opcode 0010011), mem_rdy=1: ir_we at cycle 0; rf_we, pc_we, pc_sel=0, retire at cycle 3; num_inst=1.
REQ-046 BEQ with branch_taken=1: pc_we with pc_sel=1 and retire at cycle 2; rf_we and mem_en stay 0.
REQ-047 LW with mem_rdy low 3 cycles: MEM held 4 cycles with mem_en=1 and mem_wen_n=1; then WB with rf_we=1; total 8 cycles.
REQ-048 SW with mem_rdy never high and MEM_TIMEOUT=15: after 15 MEM cycles, err=1, halt=1, state=5, mem_en=0.
REQ-049 halt_det=1 in ID: halt=1, num_inst increments once, and nothing else changes for 20 further cycles.
REQ-050 RST pulsed mid-MEM of SW: mem_en=0 and state=IF immediately; num_inst=0; no memory write observed.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types for the multi-cycle RV32I controller: state encoding,
// opcode constants, next-PC source encodings and an opcode legality check.
package riscv_mc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IF   = 3'd0;
  localparam state_t S_ID   = 3'd1;
  localparam state_t S_EX   = 3'd2;
  localparam state_t S_MEM  = 3'd3;
  localparam state_t S_WB   = 3'd4;
  localparam state_t S_HALT = 3'd5;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_LUI    = 7'b0110111;
  localparam opcode_t OP_AUIPC  = 7'b0010111;
  localparam opcode_t OP_JAL    = 7'b1101111;
  localparam opcode_t OP_JALR   = 7'b1100111;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_LOAD   = 7'b0000011;
  localparam opcode_t OP_STORE  = 7'b0100011;
  localparam opcode_t OP_OP     = 7'b0110011;
  localparam opcode_t OP_IMM    = 7'b0010011;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEQ  = 2'd0;
  localparam pc_sel_t PC_BR   = 2'd1;
  localparam pc_sel_t PC_JAL  = 2'd2;
  localparam pc_sel_t PC_JALR = 2'd3;

  function automatic logic is_legal(input opcode_t op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_LOAD, OP_STORE,
      OP_OP, OP_IMM: is_legal = 1'b1;
      default:       is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Datapath <-> controller bundle: decode/memory status in, strobes out.
// master = datapath side, slave = controller side.
interface riscv_mc_ctrl_if;
  import riscv_mc_pkg::*;

  opcode_t opcode;
  logic    branch_taken;
  logic    halt_det;
  logic    mem_rdy;

  logic    ir_we;
  logic    pc_we;
  pc_sel_t pc_sel;
  logic    rf_we;
  logic    mem_en;
  logic    mem_wen_n;
  logic    retire;

  modport master (
    output opcode, branch_taken, halt_det, mem_rdy,
    input  ir_we, pc_we, pc_sel, rf_we,
    input  mem_en, mem_wen_n, retire
  );

  modport slave (
    input  opcode, branch_taken, halt_det, mem_rdy,
    output ir_we, pc_we, pc_sel, rf_we,
    output mem_en, mem_wen_n, retire
  );
endinterface

// File: rtl/riscv_mc_ctrl_perf_cnt.sv
// Performance counters: retired-instruction count (num_inst) and, with
// MC_CTRL_CYCLE_CNT_EN, a free-running cycle_cnt gated by run.
module mc_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             retire,
`ifdef MC_CTRL_CYCLE_CNT_EN
  input  logic             run,
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic [CNT_W-1:0] num_inst
);

  logic [CNT_W-1:0] num_q, num_d;

  always_comb begin
    num_d = num_q + CNT_W'(retire);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) num_q <= '0;
    else     num_q <= num_d;
  end

  assign num_inst = num_q;

`ifdef MC_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q + CNT_W'(run);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT) driving bus.slave;
// outputs num_inst/halt/err/state, plus cycle_cnt if MC_CTRL_CYCLE_CNT_EN.
module riscv_mc_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  riscv_mc_ctrl_if.slave   bus,
`ifdef MC_CTRL_CYCLE_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic [CNT_W-1:0] num_inst,
  output logic             halt,
  output logic             err,
  output logic [2:0]       state
);

  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic             halt_q, halt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic    ir_we_c, pc_we_c, rf_we_c;
  logic    mem_en_c, mem_wen_n_c, retire_c;
  pc_sel_t pc_sel_c;
  logic    is_st, is_ld;

  assign is_st = (bus.opcode == OP_STORE);
  assign is_ld = (bus.opcode == OP_LOAD);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    halt_d      = halt_q;
    tmo_d       = tmo_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = PC_SEQ;
    rf_we_c     = 1'b0;
    mem_en_c    = 1'b0;
    mem_wen_n_c = 1'b1;
    retire_c    = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we_c = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (bus.halt_det) begin
          retire_c = 1'b1;
          halt_d   = 1'b1;
          state_d  = S_HALT;
        end else if (!is_legal(bus.opcode)) begin
          err_d   = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (bus.opcode == OP_BRANCH) begin
          pc_we_c  = 1'b1;
          pc_sel_c = bus.branch_taken ? PC_BR : PC_SEQ;
          retire_c = 1'b1;
          state_d  = S_IF;
        end else if (is_ld || is_st) begin
          tmo_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_en_c    = 1'b1;
        mem_wen_n_c = !is_st;
        if (bus.mem_rdy) begin
          tmo_d = '0;
          if (is_st) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
          // Last tolerated stall cycle: give up and park in HALT.
          tmo_d   = '0;
          err_d   = 1'b1;
          halt_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        pc_we_c  = 1'b1;
        retire_c = 1'b1;
        unique case (1'b1)
          bus.opcode == OP_JAL:  pc_sel_c = PC_JAL;
          bus.opcode == OP_JALR: pc_sel_c = PC_JALR;
          default:               pc_sel_c = PC_SEQ;
        endcase
        state_d = S_IF;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IF;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Reset kills every strobe at once, even though IF is the reset state.
  assign bus.ir_we     = ir_we_c  & ~RST;
  assign bus.pc_we     = pc_we_c  & ~RST;
  assign bus.pc_sel    = pc_sel_c;
  assign bus.rf_we     = rf_we_c  & ~RST;
  assign bus.mem_en    = mem_en_c & ~RST;
  assign bus.mem_wen_n = mem_wen_n_c | RST;
  assign bus.retire    = retire_c & ~RST;

  mc_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .CLK       (CLK),
    .RST       (RST),
    .retire    (retire_c & ~RST),
`ifdef MC_CTRL_CYCLE_CNT_EN
    .run       (state_q != S_HALT),
    .cycle_cnt (cycle_cnt),
`endif
    .num_inst  (num_inst)
  );

  assign halt  = halt_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: per-instruction expected traces built from the
// controller rules, checked every cycle, plus literal pins on counters/flags.
module tb_riscv_mc_ctrl;
  import riscv_mc_pkg::*;

  localparam int CW  = 4;
  localparam int TMO = 15;

  typedef struct {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       mem_en;
    logic       mem_wen_n;
    logic       retire;
    logic [2:0] st;
    logic       rdy;
    logic       set_err;
    logic       set_halt;
  } rec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [CW-1:0] num_inst;
  logic          halt, err;
  logic [2:0]    state;
`ifdef MC_CTRL_CYCLE_CNT_EN
  logic [CW-1:0] cycle_cnt;
`endif

  riscv_mc_ctrl_if bus ();

  riscv_mc_ctrl #(
    .CNT_W       (CW),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
`ifdef MC_CTRL_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .num_inst (num_inst),
    .halt     (halt),
    .err      (err),
    .state    (state)
  );

  always #5 CLK = ~CLK;

  int   checks = 0;
  int   failures = 0;
  rec_t e_cur;
  logic e_valid = 1'b0;
  int   m_num = 0;
  logic m_err = 1'b0;
  logic m_halt = 1'b0;
  logic [6:0] cur_op = OP_IMM;
  logic cur_tk = 1'b0;
  logic cur_hd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] st);
    rec_t r;
    r.ir_we = 0; r.pc_we = 0; r.pc_sel = 0; r.rf_we = 0;
    r.mem_en = 0; r.mem_wen_n = 1; r.retire = 0; r.st = st;
    r.rdy = 1; r.set_err = 0; r.set_halt = 0;
    return r;
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                      OP_LOAD, OP_STORE, OP_OP, OP_IMM};
  endfunction

  // Compare process: one expected record per cycle, model state updated
  // from the record's side effects after checking.
  always @(negedge CLK) begin
    #2;
    if (RST) begin
      m_num = 0; m_err = 0; m_halt = 0;
    end else if (e_valid) begin
      chk("ir_we", bus.ir_we, e_cur.ir_we);
      chk("pc_we", bus.pc_we, e_cur.pc_we);
      if (e_cur.pc_we) chk("pc_sel", bus.pc_sel, e_cur.pc_sel);
      chk("rf_we", bus.rf_we, e_cur.rf_we);
      chk("mem_en", bus.mem_en, e_cur.mem_en);
      chk("mem_wen_n", bus.mem_wen_n, e_cur.mem_wen_n);
      chk("retire", bus.retire, e_cur.retire);
      chk("state", state, e_cur.st);
      chk("num_inst", num_inst, m_num % (1 << CW));
      chk("halt", halt, m_halt);
      chk("err", err, m_err);
      chk("rf_vs_wr", bus.rf_we & ~bus.mem_wen_n, 0);
      if (e_cur.retire) m_num++;
      if (e_cur.set_err) m_err = 1;
      if (e_cur.set_halt) m_halt = 1;
    end
  end

  task automatic cyc(input rec_t r);
    @(negedge CLK);
    bus.opcode = cur_op;
    bus.branch_taken = cur_tk;
    bus.halt_det = cur_hd;
    bus.mem_rdy = r.rdy;
    e_cur = r;
    e_valid = 1'b1;
  endtask

  task automatic instr(input logic [6:0] op, input logic tk,
                       input logic hd, input int stalls);
    rec_t r;
    logic st;
    st = (op == OP_STORE);
    cur_op = op; cur_tk = tk; cur_hd = hd;
    r = mk(0); r.ir_we = 1; cyc(r);
    r = mk(1);
    if (hd) begin
      r.retire = 1; r.set_halt = 1; cyc(r); return;
    end
    if (!legal(op)) begin
      r.pc_we = 1; r.set_err = 1; cyc(r); return;
    end
    cyc(r);
    r = mk(2);
    if (op == OP_BRANCH) begin
      r.pc_we = 1; r.pc_sel = tk ? 2'd1 : 2'd0; r.retire = 1;
      cyc(r); return;
    end
    cyc(r);
    if (op == OP_LOAD || st) begin
      for (int i = 0; i < stalls; i++) begin
        r = mk(3); r.rdy = 0; r.mem_en = 1; r.mem_wen_n = !st;
        if (i + 1 == TMO) begin
          r.set_err = 1; r.set_halt = 1; cyc(r); return;
        end
        cyc(r);
      end
      r = mk(3); r.mem_en = 1; r.mem_wen_n = !st;
      if (st) begin
        r.pc_we = 1; r.retire = 1; cyc(r); return;
      end
      cyc(r);
    end
    r = mk(4); r.rf_we = 1; r.pc_we = 1; r.retire = 1;
    r.pc_sel = (op == OP_JAL) ? 2'd2 : (op == OP_JALR) ? 2'd3 : 2'd0;
    cyc(r);
  endtask

  task automatic halt_cycles(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = mk(5); r.rdy = i[0]; cyc(r);
    end
  endtask

  task automatic pin_wait;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset;
    e_valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  initial begin
    rec_t r;
    bus.opcode = OP_IMM; bus.branch_taken = 0;
    bus.halt_det = 0; bus.mem_rdy = 1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_ir_we", bus.ir_we, 0);
    chk("rst_num", num_inst, 0);
    chk("rst_halt", halt, 0);
    chk("rst_err", err, 0);
    chk("rst_wen_n", bus.mem_wen_n, 1);
    do_reset();

    instr(OP_IMM, 0, 0, 0);  pin_wait(); chk("addi_num", num_inst, 1);
    instr(OP_BRANCH, 1, 0, 0); pin_wait(); chk("beq_num", num_inst, 2);
    instr(OP_BRANCH, 0, 0, 0);
    instr(OP_LOAD, 0, 0, 3); pin_wait(); chk("lw_num", num_inst, 4);
    instr(OP_STORE, 0, 0, 0);
    instr(OP_JAL, 0, 0, 0);
    instr(OP_JALR, 0, 0, 0);
    instr(OP_LUI, 0, 0, 0);
    instr(OP_AUIPC, 0, 0, 0);
    instr(OP_OP, 0, 0, 0);
    instr(7'b1111111, 0, 0, 0);
    pin_wait(); chk("ill_err", err, 1); chk("ill_num", num_inst, 10);
    instr(OP_IMM, 0, 1, 0);
    halt_cycles(20);
    pin_wait();
    chk("hlt_halt", halt, 1); chk("hlt_num", num_inst, 11);
    chk("hlt_state", state, 5);

    do_reset();
    chk("rst2_state", state, 0); chk("rst2_num", num_inst, 0);
    chk("rst2_err", err, 0);
    instr(OP_IMM, 0, 0, 0);
    cur_op = OP_STORE; cur_tk = 0; cur_hd = 0;
    r = mk(0); r.ir_we = 1; cyc(r);
    cyc(mk(1)); cyc(mk(2));
    for (int i = 0; i < 2; i++) begin
      r = mk(3); r.rdy = 0; r.mem_en = 1; r.mem_wen_n = 0; cyc(r);
    end
    #3;
    e_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("mid_mem_en", bus.mem_en, 0);
    chk("mid_wen_n", bus.mem_wen_n, 1);
    chk("mid_state", state, 0);
    chk("mid_num", num_inst, 0);
    chk("mid_retire", bus.retire, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    instr(OP_STORE, 0, 0, TMO);
    halt_cycles(3);
    pin_wait();
    chk("to_state", state, 5); chk("to_err", err, 1);
    chk("to_halt", halt, 1); chk("to_mem_en", bus.mem_en, 0);

    do_reset();
    for (int i = 0; i < 17; i++) instr(OP_BRANCH, 0, 0, 0);
    pin_wait(); chk("wrap_num", num_inst, 1);

    e_valid = 1'b0;
    @(negedge CLK); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
